// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam int          ITER_N  = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 shift-add (multiply) or restoring (divide) step per cycle
// on 32-bit unsigned magnitudes.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] acc,
    output logic        last
);

    logic [31:0] bq;
    logic [4:0]  cnt;
    logic [32:0] mul_sum;
    logic [32:0] part;
    logic [32:0] diff;
    logic [63:0] nxt;

    // Multiply: acc = {partial hi, shrinking multiplier}.
    // Divide:   acc = {remainder, shrinking dividend / growing quotient}.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, bq} : 33'd0);
        part    = {acc[63:32], acc[31]};
        diff    = part - {1'b0, bq};
        nxt     = {mul_sum, acc[31:1]};
        if (is_div) begin
            if (!diff[32])
                nxt = {diff[31:0], acc[30:0], 1'b1};
            else
                nxt = {part[31:0], acc[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            bq  <= '0;
            cnt <= '0;
        end else if (start) begin
            acc <= {32'd0, a};
            bq  <= b;
            cnt <= 5'(ITER_N - 1);
        end else if (step) begin
            acc <= nxt;
            if (cnt != 5'd0)
                cnt <= cnt - 5'd1;
        end
    end

    assign last = (cnt == 5'd0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide responder with valid/ready request and
// response channels. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    state_t      state;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic        neg_pq;
    logic        neg_r;

    logic        a_signed;
    logic        b_signed;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div0;
    logic        ovf;
    logic        special;
    logic [31:0] spec_res;
    logic        accept;
    logic        core_start;
    logic [63:0] acc;
    logic        core_last;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_res;

    always_comb begin
        a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        b_signed = (req_op == OP_MULH) || (req_op == OP_DIV) ||
                   (req_op == OP_REM);
        sa       = a_signed & req_a[31];
        sb       = b_signed & req_b[31];
        a_mag    = sa ? -req_a : req_a;
        b_mag    = sb ? -req_b : req_b;
        div0     = req_op[2] && (req_b == 32'd0);
        ovf      = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (req_a == INT_MIN) && (req_b == DIV0_Q);
        special  = div0 || ovf;
        spec_res = 32'd0;
        if (div0)
            spec_res = req_op[1] ? req_a : DIV0_Q;
        else if (ovf)
            spec_res = req_op[1] ? 32'd0 : INT_MIN;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] fprod;
    assign fprod = 64'($signed({sa, req_a}) * $signed({sb, req_b}));
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready && !flush;

`ifdef MULDIV_FAST_MUL_EN
    assign core_start = accept && !special && req_op[2];
`else
    assign core_start = accept && !special;
`endif

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .step   (state == CALC),
        .is_div (op_q[2]),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (acc),
        .last   (core_last)
    );

    // Sign restoration of the unsigned magnitude results.
    always_comb begin
        prod    = neg_pq ? -acc : acc;
        quo     = neg_pq ? -acc[31:0] : acc[31:0];
        rem     = neg_r ? -acc[63:32] : acc[63:32];
        fix_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        if (op_q[2])
            fix_res = op_q[1] ? rem : quo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            neg_pq      <= 1'b0;
            neg_r       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_rd     <= '0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        rd_q   <= req_rd;
                        neg_pq <= sa ^ sb;
                        neg_r  <= sa;
                        if (special) begin
                            resp_result <= spec_res;
                            resp_rd     <= req_rd;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!req_op[2]) begin
                            resp_result <= (req_op == OP_MUL) ?
                                           fprod[31:0] : fprod[63:32];
                            resp_rd     <= req_rd;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (core_last)
                        state <= FIX;
                end
                FIX: begin
                    resp_result <= fix_res;
                    resp_rd     <= rd_q;
                    resp_valid  <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_rd;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 34;
`endif
    localparam int DL = 34;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_rd     (resp_rd),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res,
                          input int lat, input int hold);
        exp_t e;
        int   n;
        logic [31:0] snap;
        sb.push_back('{res: res, rd: rd, lat: lat});
        @(negedge clk);
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        check({tag, "_res"}, resp_result, e.res);
        check({tag, "_rd"}, 32'(resp_rd), 32'(e.rd));
        snap = resp_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_res"}, resp_result, snap);
            check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld_fall"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdy_rise"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_rd     = 5'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9,
               32'hFFFF_FFEB, ML, 0);
        run_op("mulh", OP_MULH, INT_MIN, INT_MIN, 5'd1,
               32'h4000_0000, ML, 0);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
               32'hFFFF_FFFE, ML, 0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
               32'hFFFF_FFFF, ML, 0);
        run_op("mulh_neg", OP_MULH, 32'hFFFF_FFFE, 32'd3, 5'd4,
               32'hFFFF_FFFF, ML, 0);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5,
               32'hFFFF_FFFD, DL, 0);
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6,
               32'hFFFF_FFFF, DL, 0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, DL, 0);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 5'd8, 32'd2, DL, 0);
        run_op("rem_negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd10,
               32'd1, DL, 0);
        run_op("div0", OP_DIV, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 0);
        run_op("rem0", OP_REM, 32'd5, 32'd0, 5'd12, 32'd5, 1, 0);
        run_op("remu0", OP_REMU, 32'hDEAD_BEEF, 32'd0, 5'd13,
               32'hDEAD_BEEF, 1, 0);
        run_op("div_ovf", OP_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd14,
               INT_MIN, 1, 0);
        run_op("rem_ovf", OP_REM, INT_MIN, 32'hFFFF_FFFF, 5'd15,
               32'd0, 1, 0);
        run_op("divu_ovf", OP_DIVU, INT_MIN, 32'hFFFF_FFFF, 5'd16,
               32'd0, DL, 0);
        run_op("bp_divu", OP_DIVU, 32'd1000, 32'd3, 5'd17, 32'd333, DL, 10);

        // Flush in the middle of an iterative divide.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd50;
        req_b     = 32'd5;
        req_rd    = 5'd18;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_mid_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_mid_busy", 32'(busy), 32'd0);
        check("flush_mid_valid", 32'(resp_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("flush_mid_no_resp", 32'(seen), 32'd0);
        run_op("after_flush", OP_DIVU, 32'd81, 32'd9, 5'd19, 32'd9, DL, 0);

        // Flush wins over a request in IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = OP_DIV;
        req_a     = 32'd5;
        req_b     = 32'd0;
        req_rd    = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("flush_idle_no_resp", 32'(seen), 32'd0);

        // Reset mid-calculation.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_REMU;
        req_a     = 32'd77;
        req_b     = 32'd10;
        req_rd    = 5'd21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(resp_valid), 32'd0);
        run_op("after_rst", OP_REMU, 32'd77, 32'd10, 5'd22, 32'd7, DL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
